// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: the serial line in, the received byte,
// its strobes and the busy/state observation signals out.
interface uart_rx_if;
    logic       serial_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;
    logic [2:0] rx_state;

    // Receiver side: consumes the line, produces the byte and strobes.
    modport slave (
        input  serial_rxd,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy,
        output rx_state
    );

    // Line driver / consumer side.
    modport master (
        output serial_rxd,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_busy,
        input  rx_state
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop line synchronizer and mid-bit sampling.
// Strobe semantics: rx_valid and rx_frame_err are single-cycle, registered,
// mutually exclusive pulses with no back-pressure; rx_data is stable from
// the rx_valid pulse until the next good frame overwrites it.
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 86
) (
    input logic     clk,
    input logic     rst_n,
    uart_rx_if.slave rx
);
    localparam int CW = $clog2(CLOCKS_PER_BIT);

    // Last count of a full bit period, and of the initial half-bit wait.
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] START_LAST = CW'((CLOCKS_PER_BIT - 1) / 2 - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic          rxd_meta_q, rxd_meta_d;
    logic          rxd_s_q,    rxd_s_d;
    logic          rxd_prev_q, rxd_prev_d;
    logic [2:0]    state_q,    state_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [2:0]    bit_idx_q,  bit_idx_d;
    logic [7:0]    shift_q,    shift_d;
    logic [7:0]    data_q,     data_d;
    logic          valid_q,    valid_d;
    logic          ferr_q,     ferr_d;

    // Synchronizer chain plus one history flop for start-edge detection.
    always_comb begin
        rxd_meta_d = rx.serial_rxd;
        rxd_s_d    = rxd_meta_q;
        rxd_prev_d = rxd_s_q;
    end

    // Frame FSM: the half-bit START wait puts every later sample mid-bit,
    // and leaving STOP at its midpoint lets a back-to-back start be seen.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                if (!rxd_s_q && rxd_prev_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rxd_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxd_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (rxd_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; the synchronizer resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rxd_meta_q <= rxd_meta_d;
            rxd_s_q    <= rxd_s_d;
            rxd_prev_q <= rxd_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx.rx_data      = data_q;
    assign rx.rx_valid     = valid_q;
    assign rx.rx_frame_err = ferr_q;
    assign rx.rx_busy      = (state_q != ST_IDLE);
    assign rx.rx_state     = state_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, glitch, framing error with long break,
// reset mid-frame, then a random byte stream with baud offset.
module tb_uart_rx;
    localparam int  CPB    = 16;
    localparam int  CLK_P  = 10;
    localparam real BIT_T  = 160.0;
    localparam int  LAT    = 2 + (CPB - 1) / 2 + 9 * CPB + 1;
    localparam int  W      = 42;
    localparam int  N_RAND = 256;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    // entry = {is_err, check_latency, start_cycle[31:0], expected rx_data[7:0]}
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    logic [7:0]   model_data;
    bit           prev_pulse;

    uart_rx_if bus();

    uart_rx #(.CLOCKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (bus)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #(CLK_P / 2) clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    task automatic drive_bit(input logic b, input real t);
        bus.serial_rxd = b;
        #(t);
    endtask

    // Drive one 8N1 frame; the expectation is queued as the start bit goes out.
    task automatic send_frame(input logic [7:0] d, input logic stop, input real bt,
                              input bit align, input bit chk_lat);
        if (align) begin
            @(posedge clk);
            #1;
        end
        if (stop) model_data = d;
        exp_q.push_back({~stop, chk_lat, 32'(cyc), model_data});
        drive_bit(1'b0, bt);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bt);
        drive_bit(stop, bt);
    endtask

    // Monitor: pops one expectation per output pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rx_valid || bus.rx_frame_err) begin
                check("pulse_exclusive", 32'(bus.rx_valid & bus.rx_frame_err), 32'd0);
                check("pulse_width", 32'(prev_pulse), 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=%02h, required no pulse (t=%0t)",
                             bus.rx_valid, bus.rx_frame_err, bus.rx_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_kind_err", 32'(bus.rx_frame_err), 32'(mon_e[41]));
                    check("rx_data", 32'(bus.rx_data), 32'(mon_e[7:0]));
                    if (mon_e[40]) check_range("latency", cyc - int'(mon_e[39:8]), LAT - 1, LAT + 1);
                end
            end
            prev_pulse = bus.rx_valid | bus.rx_frame_err;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    // Watchdog
    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int busy_cnt;
        logic [7:0] d;
        real bt;
        n_cmp      = 0;
        n_bad      = 0;
        model_data = 8'h00;
        prev_pulse = 1'b0;
        bus.serial_rxd = 1'b1;
        rst_n = 1'b0;

        // Reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data", 32'(bus.rx_data), 32'h00);
        check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("reset_rx_frame_err", 32'(bus.rx_frame_err), 32'd0);
        check("reset_rx_busy", 32'(bus.rx_busy), 32'd0);
        check("reset_state_idle", 32'(bus.rx_state), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Single good frame
        send_frame(8'hA5, 1'b1, BIT_T, 1'b1, 1'b1);
        #(2 * BIT_T);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, BIT_T, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, BIT_T, 1'b0, 1'b1);
        #(2 * BIT_T);
        check("drain_b2b", 32'(exp_q.size()), 32'd0);

        // 5-cycle glitch on idle line
        @(posedge clk);
        #1;
        bus.serial_rxd = 1'b0;
        #(5 * CLK_P);
        bus.serial_rxd = 1'b1;
        busy_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.rx_busy) busy_cnt++;
        end
        check_range("glitch_busy_cycles", busy_cnt, 1, 7);
        check("glitch_busy_after", 32'(bus.rx_busy), 32'd0);
        check("glitch_state_idle", 32'(bus.rx_state), 32'd0);
        check("glitch_rx_data", 32'(bus.rx_data), 32'(model_data));

        // Stop bit low, then a long break, then a good frame
        send_frame(8'h3C, 1'b0, BIT_T, 1'b1, 1'b1);
        #(40 * BIT_T);
        @(negedge clk);
        check("break_rx_data_held", 32'(bus.rx_data), 32'hFF);
        bus.serial_rxd = 1'b1;
        #(3 * BIT_T);
        @(negedge clk);
        check("break_exit_idle", 32'(bus.rx_busy), 32'd0);
        send_frame(8'h5A, 1'b1, BIT_T, 1'b1, 1'b1);
        #(2 * BIT_T);
        check("drain_break", 32'(exp_q.size()), 32'd0);

        // Reset during data bit 4 of 8'hC3, released during bit 6 (line high)
        d = 8'hC3;
        @(posedge clk);
        #1;
        drive_bit(1'b0, BIT_T);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                bus.serial_rxd = d[i];
                #(BIT_T / 2);
                rst_n = 1'b0;
                model_data = 8'h00;
                #(BIT_T / 2);
            end else if (i == 6) begin
                bus.serial_rxd = d[i];
                #(BIT_T / 2);
                rst_n = 1'b1;
                #(BIT_T / 2);
            end else begin
                drive_bit(d[i], BIT_T);
            end
        end
        drive_bit(1'b1, BIT_T);
        #(2 * BIT_T);
        @(negedge clk);
        check("post_reset_rx_data", 32'(bus.rx_data), 32'h00);
        check("post_reset_busy", 32'(bus.rx_busy), 32'd0);
        send_frame(8'h81, 1'b1, BIT_T, 1'b1, 1'b1);
        #(2 * BIT_T);
        check("drain_reset", 32'(exp_q.size()), 32'd0);

        // Random stream with up to +/-2% baud offset and small idle gaps
        for (int n = 0; n < N_RAND; n++) begin
            bt = BIT_T * real'($urandom_range(980, 1020)) / 1000.0;
            if ($urandom_range(0, 3) == 0) begin
                bus.serial_rxd = 1'b1;
                #(real'($urandom_range(1, 40)) * CLK_P);
            end
            send_frame(8'($urandom_range(0, 255)), 1'b1, bt, 1'b0, 1'b0);
        end
        bus.serial_rxd = 1'b1;
        #(4 * BIT_T);
        check("drain_random", 32'(exp_q.size()), 32'd0);
        check("final_rx_data", 32'(bus.rx_data), 32'(model_data));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
